// File: rtl/fop_scan.sv
// fop_scan: steps a nibble range through an external Fibonacci-or-prime
// detector and collects a hit mask, hit count and lowest hit.
module fop_scan (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  lo,
  input  logic [3:0]  hi,
  output logic [3:0]  nib,
  input  logic        det,
  output logic        busy,
  output logic        done,
  output logic        range_err,
  output logic [15:0] hit_mask,
  output logic [4:0]  hit_cnt,
  output logic [3:0]  first_hit,
  output logic        first_vld
);

  localparam int unsigned NIB_W = 4;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [NIB_W-1:0] hi_q;

  // Scan sequencer with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hi_q      <= '0;
      nib       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      range_err <= 1'b0;
      hit_mask  <= '0;
      hit_cnt   <= '0;
      first_hit <= '0;
      first_vld <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            hit_mask  <= '0;
            hit_cnt   <= '0;
            first_vld <= 1'b0;
            busy      <= 1'b1;
            if (lo <= hi) begin
              hi_q      <= hi;
              nib       <= lo;
              range_err <= 1'b0;
              state     <= SCAN;
            end else begin
              // Empty range: skip straight to the completion pulse, nib untouched.
              range_err <= 1'b1;
              done      <= 1'b1;
              state     <= DONE;
            end
          end
        end
        SCAN: begin
          if (det) begin
            hit_mask[nib] <= 1'b1;
            hit_cnt       <= CNT_W'(hit_cnt + CNT_W'(1));
            if (!first_vld) begin
              first_hit <= nib;
              first_vld <= 1'b1;
            end
          end
          // Stop on the last nibble so nib never wraps past 15.
          if (nib == hi_q) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            nib <= NIB_W'(nib + NIB_W'(1));
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fop_scan.sv
// Directed bench for fop_scan with a golden Fibonacci-or-prime detector.
module tb_fop_scan;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  lo;
  logic [3:0]  hi;
  logic [3:0]  nib;
  logic        det;
  logic        busy;
  logic        done;
  logic        range_err;
  logic [15:0] hit_mask;
  logic [4:0]  hit_cnt;
  logic [3:0]  first_hit;
  logic        first_vld;

  int n_checks = 0;
  int n_errors = 0;

  // Fibonacci or prime nibbles: 0,1,2,3,5,7,8,11,13.
  logic [15:0] golden;
  assign golden = 16'h29AF;
  assign det    = golden[nib];

  fop_scan dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .lo        (lo),
    .hi        (hi),
    .nib       (nib),
    .det       (det),
    .busy      (busy),
    .done      (done),
    .range_err (range_err),
    .hit_mask  (hit_mask),
    .hit_cnt   (hit_cnt),
    .first_hit (first_hit),
    .first_vld (first_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_results(input string tag, input logic [15:0] m, input int c,
                               input logic [3:0] f, input logic fv, input logic re);
    check({tag, "_mask"}, 32'(hit_mask), 32'(m));
    check({tag, "_cnt"}, 32'(hit_cnt), 32'(c));
    if (fv) check({tag, "_first"}, 32'(first_hit), 32'(f));
    check({tag, "_fvld"}, 32'(first_vld), 32'(fv));
    check({tag, "_rerr"}, 32'(range_err), 32'(re));
  endtask

  // One scan request; inj pulses a second start (lo=0) in the third SCAN cycle.
  task automatic run_scan(input string tag, input logic [3:0] lo_v, input logic [3:0] hi_v,
                          input bit inj, input logic [15:0] m, input int c,
                          input logic [3:0] f, input logic fv);
    int cyc;
    int exp_cyc;
    bit re;
    re      = (lo_v > hi_v);
    exp_cyc = re ? 1 : (int'(hi_v) - int'(lo_v) + 2);
    start = 1'b1;
    lo    = lo_v;
    hi    = hi_v;
    tick();
    start = 1'b0;
    cyc   = 1;
    check({tag, "_rerr_early"}, 32'(range_err), 32'(re));
    while (!done && cyc < 40) begin
      check({tag, "_nib"}, 32'(nib), 32'(lo_v) + 32'(cyc - 1));
      check({tag, "_busy"}, 32'(busy), 32'd1);
      if (inj && cyc == 3) begin
        start = 1'b1;
        lo    = 4'd0;
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_busy_done"}, 32'(busy), 32'd1);
    if (!re) check({tag, "_nib_hold"}, 32'(nib), 32'(hi_v));
    check_results(tag, m, c, f, fv, re);
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    check_results({tag, "_held"}, m, c, f, fv, re);
  endtask

  initial begin
    int cyc;
    rst   = 1'b1;
    start = 1'b0;
    lo    = 4'd0;
    hi    = 4'd0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_nib", 32'(nib), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check_results("rst", 16'h0000, 0, 4'd0, 1'b0, 1'b0);
    check("rst_first_hit", 32'(first_hit), 32'd0);

    run_scan("full",    4'd0,  4'd15, 1'b0, 16'h29AF, 9, 4'd0,  1'b1);
    run_scan("nohit",   4'd9,  4'd10, 1'b0, 16'h0000, 0, 4'd0,  1'b0);
    run_scan("single",  4'd13, 4'd13, 1'b0, 16'h2000, 1, 4'd13, 1'b1);
    run_scan("rangeerr",4'd5,  4'd3,  1'b0, 16'h0000, 0, 4'd0,  1'b0);
    run_scan("clr_rerr",4'd2,  4'd3,  1'b0, 16'h000C, 2, 4'd2,  1'b1);
    run_scan("midstart",4'd4,  4'd15, 1'b1, 16'h29A0, 5, 4'd5,  1'b1);

    // Reset in the middle of a full scan discards everything.
    start = 1'b1;
    lo    = 4'd0;
    hi    = 4'd15;
    tick();
    start = 1'b0;
    cyc   = 0;
    while (nib != 4'd6 && cyc < 40) begin
      tick();
      cyc++;
    end
    check("abort_reach6", 32'(nib), 32'd6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_nib", 32'(nib), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_first_hit", 32'(first_hit), 32'd0);
    check_results("abort", 16'h0000, 0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("abort_no_done", 32'(done), 32'd0);
    end
    check("abort_idle_nib", 32'(nib), 32'd0);

    run_scan("after_rst", 4'd7, 4'd8, 1'b0, 16'h0180, 2, 4'd7, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
